spi_input_frontend: RTL



---
 rtl/spi_input_frontend.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spi_input_frontend.sv
// SPI pad conditioning: per-pin two-flop synchronizer, stability-counter glitch
// filter and registered edge pulses for sck, cs and mosi.

module spi_input_frontend_chan #(
   parameter int unsigned COUNTER_WIDTH = 3,
   parameter int unsigned WAIT_TIME     = 3,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic pin_i,
   output logic cond_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [COUNTER_WIDTH-1:0] WAIT_LAST = COUNTER_WIDTH'(WAIT_TIME - 1);

   logic                     sync0_q, sync1_q;
   logic                     cond_q, cond_d;
   logic                     rise_q, rise_d;
   logic                     fall_q, fall_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;

   always_comb begin
      cond_d  = cond_q;
      count_d = count_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync1_q == cond_q) begin
         count_d = '0;
      end else if (count_q == WAIT_LAST) begin
         // sync1 has disagreed with cond for WAIT_TIME consecutive edges: commit
         cond_d  = sync1_q;
         count_d = '0;
         rise_d  = sync1_q;
         fall_d  = ~sync1_q;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync0_q <= RESET_LEVEL;
         sync1_q <= RESET_LEVEL;
         cond_q  <= RESET_LEVEL;
         count_q <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync0_q <= pin_i;
         sync1_q <= sync0_q;
         cond_q  <= cond_d;
         count_q <= count_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign cond_o = cond_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

module spi_input_frontend #(
   parameter int unsigned COUNTER_WIDTH = 3,
   parameter int unsigned WAIT_TIME     = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sck_pin,
   input  logic cs_pin,
   input  logic mosi_pin,
   output logic sck_cond,
   output logic cs_cond,
   output logic mosi_cond,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_fall,
   output logic cs_rise
);

   logic mosi_rise_unused, mosi_fall_unused;

   spi_input_frontend_chan #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .WAIT_TIME     (WAIT_TIME),
      .RESET_LEVEL   (1'b0)
   ) u_sck (
      .clk_i   (clk),
      .reset_i (reset),
      .pin_i   (sck_pin),
      .cond_o  (sck_cond),
      .rise_o  (sck_rise),
      .fall_o  (sck_fall)
   );

   // cs resets high so the core sees a deselected bus out of reset
   spi_input_frontend_chan #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .WAIT_TIME     (WAIT_TIME),
      .RESET_LEVEL   (1'b1)
   ) u_cs (
      .clk_i   (clk),
      .reset_i (reset),
      .pin_i   (cs_pin),
      .cond_o  (cs_cond),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_input_frontend_chan #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .WAIT_TIME     (WAIT_TIME),
      .RESET_LEVEL   (1'b0)
   ) u_mosi (
      .clk_i   (clk),
      .reset_i (reset),
      .pin_i   (mosi_pin),
      .cond_o  (mosi_cond),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   logic unused_ok;
   assign unused_ok = mosi_rise_unused ^ mosi_fall_unused;

endmodule
